// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg : AXI3 constants and write-FSM state type for sram_axi_bridge
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package axi_pkg;
  localparam int         c_ID_W         = 4;
  localparam logic [7:0] c_LEN_SINGLE   = 8'h00;
  localparam logic [1:0] c_BURST_INCR   = 2'b01;
  localparam logic [1:0] c_LOCK_NORMAL  = 2'b00;
  localparam logic [3:0] c_CACHE_NONE   = 4'h0;
  localparam logic [2:0] c_PROT_NONE    = 3'b000;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wstate_e;
endpackage

`default_nettype wire

// File: rtl/sram_axi_bridge_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin one-hot grant; pointer moves only on accept
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] r_ptr;
  logic          w_found;
  int            w_c;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < N; k++) begin
      w_c = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[w_c]) begin
        o_grant[w_c] = 1'b1;
        o_idx        = PW'(w_c);
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (i_accept)
      r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge : NCH sram-like masters onto one AXI3 master, single beats
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        m_req,
  input  logic [NCH-1:0]        m_wr,
  input  logic [2*NCH-1:0]      m_size,
  input  logic [DW/8*NCH-1:0]   m_wstrb,
  input  logic [AW*NCH-1:0]     m_addr,
  input  logic [DW*NCH-1:0]     m_wdata,
  output logic [NCH-1:0]        m_addr_ok,
  output logic [NCH-1:0]        m_data_ok,
  output logic [DW*NCH-1:0]     m_rdata,
  output logic [3:0]            arid,
  output logic [AW-1:0]         araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DW-1:0]         rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [AW-1:0]         awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DW-1:0]         wdata,
  output logic [DW/8-1:0]       wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] w_grant, w_inc, w_dec;
  logic [PW-1:0]  w_idx;
  logic           w_sel_wr, w_sel_ok, w_hazard, w_rid_ok;
  logic           w_rd_acc, w_wr_acc;
  logic [AW-1:0]  w_sel_addr;
  logic [1:0]     w_sel_size;
  logic [SW-1:0]  w_sel_strb;
  logic [DW-1:0]  w_sel_wdata;
  logic [CW-1:0]  r_cnt [NCH];

  logic           r_arvalid;
  logic [AW-1:0]  r_araddr;
  logic [3:0]     r_arid;
  logic [1:0]     r_arsize;

  wstate_e        r_wstate, w_wstate_nxt;
  logic [AW-1:0]  r_waddr;
  logic [DW-1:0]  r_wdata;
  logic [SW-1:0]  r_wstrb;
  logic [1:0]     r_wsize;
  logic [PW-1:0]  r_widx;
  logic           r_aw_done, r_w_done;

  wire w_unused = ^{rresp, rlast, bid, bresp};

  rr_arbiter #(.N(NCH), .PW(PW)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (m_req),
    .i_accept (w_rd_acc | w_wr_acc),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_rid_ok = rvalid && (32'(rid) < NCH);

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NCH; i++)
      if (w_rid_ok && (32'(rid) == i)) w_dec[i] = 1'b1;
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_size  = '0;
    w_sel_strb  = '0;
    w_sel_wdata = '0;
    w_sel_ok    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_sel_wr    = m_wr[i];
        w_sel_addr  = m_addr[i*AW +: AW];
        w_sel_size  = m_size[2*i +: 2];
        w_sel_strb  = m_wstrb[i*SW +: SW];
        w_sel_wdata = m_wdata[i*DW +: DW];
        // a same-cycle return frees a slot for the channel at its limit
        w_sel_ok    = (r_cnt[i] < CW'(MAX_OUT)) || w_dec[i];
      end
    end
  end

  assign w_hazard  = (r_wstate != W_IDLE) && (w_sel_addr[AW-1:2] == r_waddr[AW-1:2]);
  assign w_rd_acc  = (|w_grant) && !w_sel_wr && (!r_arvalid || arready) && w_sel_ok && !w_hazard;
  assign w_wr_acc  = (|w_grant) && w_sel_wr && (r_wstate == W_IDLE);
  assign w_inc     = w_rd_acc ? w_grant : '0;
  assign m_addr_ok = (w_rd_acc || w_wr_acc) ? w_grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arsize  <= '0;
    end else if (w_rd_acc) begin
      r_arvalid <= 1'b1;
      r_araddr  <= w_sel_addr;
      r_arid    <= c_ID_W'(w_idx);
      r_arsize  <= w_sel_size;
    end else if (arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_acc) w_wstate_nxt = W_REQ;
      W_REQ:   if ((r_aw_done || awready) && (r_w_done || wready)) w_wstate_nxt = W_RESP;
      W_RESP:  if (bvalid) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wsize   <= '0;
      r_widx    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_acc) begin
      r_waddr   <= w_sel_addr;
      r_wdata   <= w_sel_wdata;
      r_wstrb   <= w_sel_strb;
      r_wsize   <= w_sel_size;
      r_widx    <= w_idx;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_wstate == W_REQ) begin
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
    end
  end

  assign m_data_ok = w_dec | (((r_wstate == W_RESP) && bvalid) ? (NCH'(1) << r_widx) : '0);
  assign m_rdata   = {NCH{rdata}};

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = c_LEN_SINGLE;
  assign arsize  = {1'b0, r_arsize};
  assign arburst = c_BURST_INCR;
  assign arlock  = c_LOCK_NORMAL;
  assign arcache = c_CACHE_NONE;
  assign arprot  = c_PROT_NONE;
  assign arvalid = r_arvalid;
  assign rready  = 1'b1;

  assign awid    = c_ID_W'(r_widx);
  assign awaddr  = r_waddr;
  assign awlen   = c_LEN_SINGLE;
  assign awsize  = {1'b0, r_wsize};
  assign awburst = c_BURST_INCR;
  assign awlock  = c_LOCK_NORMAL;
  assign awcache = c_CACHE_NONE;
  assign awprot  = c_PROT_NONE;
  assign awvalid = (r_wstate == W_REQ) && !r_aw_done;
  assign wid     = c_ID_W'(r_widx);
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (r_wstate == W_REQ) && !r_w_done;
  assign bready  = 1'b1;

endmodule

`default_nettype wire

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Converts NCH sram-like master channels into one AXI3 master port.
- Replaces the direct inst/data SRAM connections of the pipeline top: channel 0 is IF, channel 1 is EX/MEM.
- Single-beat transfers only.
- Supports multiple outstanding reads per channel, one write in flight, and read-after-write ordering protection.

Parameters:
- NCH, 2, number of sram-like master channels (1..8); the channel index is used directly as the AXI ID.
- AW, 32, address width.
- DW, 32, data width (DW/8 strobe bits).
- MAX_OUT, 4, maximum outstanding reads per channel; counter width is clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m_req  in  NCH  per-channel request
- m_wr  in  NCH  1 = write
- m_size  in  2*NCH  0/1/2 = byte/half/word
- m_wstrb  in  DW/8*NCH  write byte strobes
- m_addr  in  AW*NCH  request address
- m_wdata  in  DW*NCH  write data
- m_addr_ok  out  NCH  request accepted this cycle
- m_data_ok  out  NCH  read data / write completion this cycle
- m_rdata  out  DW*NCH  read data, valid with data_ok
- arid/awid/wid  out  4  channel index
- araddr/awaddr  out  AW  address
- arlen/awlen  out  8  constant 0
- arsize/awsize  out  3  {1'b0,size}
- arburst/awburst  out  2  constant 2'b01
- arlock/awlock/arcache/awcache/arprot/awprot  out  2/4/3  constant 0
- arvalid/arready  out/in  1  read-address handshake
- rid  in  4  read ID
- rdata  in  DW  read data
- rresp  in  2  ignored
- rlast  in  1  ignored
- rvalid  in  1  read-data valid
- rready  out  1  constant 1
- awvalid/awready  out/in  1  write-address handshake
- wdata  out  DW  write data
- wstrb  out  DW/8  write strobes
- wlast  out  1  constant 1
- wvalid/wready  out/in  1  write-data handshake
- bid  in  4  write-response ID
- bresp  in  2  ignored
- bvalid  in  1  write-response valid
- bready  out  1  constant 1

Behaviour:

Reset:
- All valids low, all m_addr_ok/m_data_ok 0.
- Outstanding counters 0, round-robin pointer 0, write FSM in W_IDLE, AR slot empty.

Arbitration:
- Each cycle a round-robin arbiter grants one requesting channel, searching from ptr.
- ptr advances to grant+1 (mod NCH) only when the grant is accepted.

Read accept:
- Conditions: granted, !m_wr, AR slot empty (or handshaking this cycle), cnt[ch] < MAX_OUT, and no RAW hazard.
- RAW hazard: write FSM not in W_IDLE and m_addr[AW-1:2] == write address[AW-1:2].
- On accept, in the same cycle: m_addr_ok[ch]=1, AR slot loaded; arvalid=1 from the next cycle until arready.
- Back-to-back accept allowed when the slot is freed that cycle.

Read return:
- On rvalid with rid<NCH: m_data_ok[rid]=1 and m_rdata[rid]=rdata in the same cycle (combinational), cnt[rid] decrements.
- rid>=NCH is dropped.
- Simultaneous inc/dec on one channel leaves cnt unchanged.

Write FSM:
- W_IDLE: granted write accepted only here; m_addr_ok=1, address/data/strobe/ID registered → W_REQ.
- W_REQ: awvalid and wvalid both 1. Each deasserts independently after its own handshake; when both are done → W_RESP.
- W_RESP: on bvalid → m_data_ok[wid]=1 for one cycle → W_IDLE.
- A write request while not in W_IDLE is not accepted, and the arbiter still rotates only on acceptance.
- Reads from other channels proceed during a write unless hazarded.

Ordering:
- Reads complete in order per channel, relying on AXI same-ID ordering.
- m_data_ok for a write never coincides with a read data_ok on the same channel unless both are legitimately due; both then assert in the same cycle.

Reset mid-operation:
- All state is cleared asynchronously; in-flight AXI transactions are abandoned.

Decomposition:
- Package axi_pkg: burst/len/size/cache constants, write FSM state enum (W_IDLE/W_REQ/W_RESP), ID width 4.
- Sub-module: rr_arbiter (NCH request vector, accept input, one-hot grant, registered pointer).

Test Plan:
- Single read, ch0 addr 0x1c000000, arready=1, rvalid 3 cycles later with 0xDEADBEEF → addr_ok same cycle, arvalid next cycle, data_ok[0] with 0xDEADBEEF, cnt back to 0.
- ch0 issues 5 reads with no responses, MAX_OUT=4 → 4th accepted; 5th held with addr_ok=0 until the first rvalid, then accepted the same cycle.
- ch0 and ch1 both request reads every cycle → grants alternate 0,1,0,1; arid matches the granted channel.
- ch1 write to 0x100 (wstrb 4'b0011), awready delayed 2 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 3; data_ok[1] the cycle bvalid=1.
- ch1 write to 0x100 pending, ch0 reads 0x102 → read blocked until W_IDLE; read of 0x200 accepted meanwhile.
- reset asserted with 2 reads outstanding and the write FSM in W_REQ → all valids 0 immediately, counters 0, a new read accepted right after release.
